// File: rtl/wb_mux_tmo_if.sv
// Wishbone B4 classic bus bundle for wb_mux_tmo: one master side plus NUM_SLAVES flattened slave
// ports (index 0 at the LSBs). The "slave" modport is the mux's view; "master" is the driver's view.
interface wb_mux_tmo_if #(
  parameter int NUM_SLAVES = 6,
  parameter int DW         = 32,
  parameter int AW         = 32
);
  logic [AW-1:0]              wbm_adr_i;
  logic [DW-1:0]              wbm_dat_i;
  logic [DW/8-1:0]            wbm_sel_i;
  logic                       wbm_we_i;
  logic                       wbm_cyc_i;
  logic                       wbm_stb_i;
  logic [2:0]                 wbm_cti_i;
  logic [1:0]                 wbm_bte_i;
  logic [DW-1:0]              wbm_dat_o;
  logic                       wbm_ack_o;
  logic                       wbm_err_o;
  logic                       wbm_rty_o;

  logic [NUM_SLAVES*AW-1:0]   wbs_adr_o;
  logic [NUM_SLAVES*DW-1:0]   wbs_dat_o;
  logic [NUM_SLAVES*DW/8-1:0] wbs_sel_o;
  logic [NUM_SLAVES-1:0]      wbs_we_o;
  logic [NUM_SLAVES*3-1:0]    wbs_cti_o;
  logic [NUM_SLAVES*2-1:0]    wbs_bte_o;
  logic [NUM_SLAVES-1:0]      wbs_cyc_o;
  logic [NUM_SLAVES-1:0]      wbs_stb_o;
  logic [NUM_SLAVES*DW-1:0]   wbs_dat_i;
  logic [NUM_SLAVES-1:0]      wbs_ack_i;
  logic [NUM_SLAVES-1:0]      wbs_err_i;
  logic [NUM_SLAVES-1:0]      wbs_rty_i;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o
  );
endinterface

// File: rtl/wb_mux_tmo.sv
// Wishbone 1:N decoder/mux with registered slave select, bus error on unmapped or timed-out
// accesses, and sticky capture of the first fault. Strobe 1 cycle after request; ack passes same cycle.
module wb_mux_tmo #(
  parameter int NUM_SLAVES = 6,
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR =
    {32'h20000200, 32'h00000000, 32'h10000000, 32'h20000100, 32'h20000000, 32'h20000c00},
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK =
    {32'hffffff00, 32'hf0000000, 32'hf0000000, 32'hffffff00, 32'hffffff00, 32'hffffff00},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  wb_mux_tmo_if.slave   bus,
  input  logic          err_clr_i,
  output logic          err_valid_o,
  output logic [AW-1:0] err_addr_o,
  output logic [1:0]    err_cause_o,
  output logic          err_ovf_o
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    ERR  = 2'b10
  } state_t;

  state_t        state;
  logic [SW-1:0] sel_q;
  logic [CW-1:0] cnt;

  logic          hit_any;
  logic [SW-1:0] hit_idx;
  logic [DW-1:0] sel_dat;
  logic          sel_ack;
  logic          sel_err;
  logic          sel_rty;
  logic          busy;
  logic          req;
  logic          resp;
  logic          tmo_hit;
  logic          err_go;
  logic [1:0]    err_cause_nxt;

  assign bus.wbs_adr_o = {NUM_SLAVES{bus.wbm_adr_i}};
  assign bus.wbs_dat_o = {NUM_SLAVES{bus.wbm_dat_i}};
  assign bus.wbs_sel_o = {NUM_SLAVES{bus.wbm_sel_i}};
  assign bus.wbs_we_o  = {NUM_SLAVES{bus.wbm_we_i}};
  assign bus.wbs_cti_o = {NUM_SLAVES{bus.wbm_cti_i}};
  assign bus.wbs_bte_o = {NUM_SLAVES{bus.wbm_bte_i}};

  // Walk downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (((bus.wbm_adr_i ^ MATCH_ADDR[i*AW +: AW]) & MATCH_MASK[i*AW +: AW]) == '0) begin
        hit_any = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign busy = (state == BUSY);

  always_comb begin
    sel_dat       = '0;
    sel_ack       = 1'b0;
    sel_err       = 1'b0;
    sel_rty       = 1'b0;
    bus.wbs_cyc_o = '0;
    bus.wbs_stb_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SW'(i)) begin
        sel_dat          = bus.wbs_dat_i[i*DW +: DW];
        sel_ack          = bus.wbs_ack_i[i];
        sel_err          = bus.wbs_err_i[i];
        sel_rty          = bus.wbs_rty_i[i];
        bus.wbs_cyc_o[i] = busy & bus.wbm_cyc_i;
        bus.wbs_stb_o[i] = busy & bus.wbm_stb_i;
      end
    end
  end

  assign bus.wbm_dat_o = busy ? sel_dat : '0;
  assign bus.wbm_ack_o = busy & sel_ack;
  assign bus.wbm_rty_o = busy & sel_rty;
  // The ERR pulse is suppressed if the master has already given up the cycle.
  assign bus.wbm_err_o = (busy & sel_err) | ((state == ERR) & bus.wbm_cyc_i);

  assign req     = bus.wbm_cyc_i & bus.wbm_stb_i;
  assign resp    = sel_ack | sel_err | sel_rty;
  assign tmo_hit = TMO_EN && (cnt == TMO_LAST);

  // A slave response on the final timeout cycle wins over the timeout.
  assign err_go        = ((state == IDLE) & req & ~hit_any)
                       | (busy & bus.wbm_cyc_i & ~resp & tmo_hit);
  assign err_cause_nxt = (state == IDLE) ? CAUSE_UNMAPPED : CAUSE_TIMEOUT;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      sel_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit_any) begin
              state <= BUSY;
              sel_q <= hit_idx;
              cnt   <= '0;
            end else begin
              state <= ERR;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (resp || !bus.wbm_cyc_i) begin
            state <= IDLE;
          end else if (tmo_hit) begin
            state <= ERR;
          end
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A clear in the same cycle as a new fault makes room for that fault.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_cause_o <= 2'b00;
      err_ovf_o   <= 1'b0;
    end else if (err_go) begin
      if (!err_valid_o || err_clr_i) begin
        err_valid_o <= 1'b1;
        err_addr_o  <= bus.wbm_adr_i;
        err_cause_o <= err_cause_nxt;
        err_ovf_o   <= 1'b0;
      end else begin
        err_ovf_o <= 1'b1;
      end
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
      err_ovf_o   <= 1'b0;
    end
  end

endmodule

// File: doc/wb_mux_tmo.md
Name: wb_mux_tmo

Overview:
- Parametrised N-slave Wishbone B4 classic address decoder and multiplexer for the SoC data bus, one master to NUM_SLAVES slaves.
- Registers the slave select for each cycle, so decode is not in the return path.
- Returns a bus error for unmapped addresses and for slaves that never respond within TIMEOUT_CYCLES.
- Captures the first faulting address and its cause in sticky status outputs for the CLINT or debug.

Parameters:
- NUM_SLAVES, 6, number of slave ports, 1..16.
- DW, 32, data width; sel width is DW/8.
- AW, 32, address width.
- MATCH_ADDR, {32'h20000200,32'h00000000,32'h10000000,32'h20000100,32'h20000000,32'h20000c00}, per-slave base, NUM_SLAVES*AW bits, index 0 at the LSBs (0=CLINT, 1=UART, 2=GPIO, 3=IMEM, 4=DMEM, 5=SPI).
- MATCH_MASK, {32'hffffff00,32'hf0000000,32'hf0000000,32'hffffff00,32'hffffff00,32'hffffff00}, per-slave mask, same packing.
- TIMEOUT_CYCLES, 255, cycles in BUSY before a timeout error; 0 disables the timeout.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- wbm_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i  in  AW/DW/DW/8/1/1/1/3/2  master request.
- wbm_dat_o/ack_o/err_o/rty_o  out  DW/1/1/1  master response.
- wbs_adr_o/dat_o/sel_o/we_o/cti_o/bte_o  out  NUM_SLAVES x (AW/DW/DW/8/1/3/2)  slave request, flattened, index 0 at the LSBs.
- wbs_cyc_o, wbs_stb_o  out  NUM_SLAVES  per-slave qualified strobes.
- wbs_dat_i  in  NUM_SLAVES*DW  slave read data.
- wbs_ack_i, wbs_err_i, wbs_rty_i  in  NUM_SLAVES  slave responses.
- err_valid_o  out  1  sticky: an error has been captured.
- err_addr_o  out  AW  address of the first captured error.
- err_cause_o  out  2  01 = unmapped, 10 = timeout.
- err_ovf_o  out  1  sticky: a further error occurred while err_valid_o was set.
- err_clr_i  in  1  clears err_valid_o and err_ovf_o.

Behaviour:
- Reset (async, active-high): state IDLE, select register 0, timeout counter 0, all error status 0. All wbs_cyc_o, wbs_stb_o and all wbm_* outputs are 0 immediately.
- adr, dat, sel, we, cti and bte are broadcast unregistered to every slave port.
- Decode: hit[i] = ((wbm_adr_i ^ MATCH_ADDR[i]) & MATCH_MASK[i]) == 0. With multiple hits, the lowest index wins.
- State machine:
  - IDLE: on wbm_cyc_i & wbm_stb_i with a hit, latch the index and go to BUSY. With no hit, go to ERR.
  - BUSY: wbs_cyc_o[sel] = wbm_cyc_i and wbs_stb_o[sel] = wbm_stb_i; all other slaves see 0. wbm_dat_o, ack, err and rty are taken combinationally from the selected slave. The counter increments every cycle.
  - BUSY exits:
    - Any of ack/err/rty from the selected slave goes to IDLE.
    - wbm_cyc_i low (master abort) goes to IDLE; the slave strobes drop in the same cycle.
    - Counter == TIMEOUT_CYCLES-1 with no response (and TIMEOUT_CYCLES != 0) drops the slave strobes and goes to ERR.
  - ERR: wbm_err_o = 1 for exactly one cycle, then IDLE. If the master drops cyc before ERR, the error is still recorded but no err pulse is driven.
- Latency: first slave strobe appears 1 cycle after the master request. Master ack appears in the same cycle as the slave ack. An unmapped access gets err 1 cycle after the request. Back-to-back accesses pay one IDLE cycle each.
- wbm_dat_o is 0 outside BUSY. Responses from unselected slaves, or while not in BUSY, are ignored.
- A slave ack in the same cycle the timeout fires: the ack wins and no error is recorded.
- Error capture:
  - When a transition to ERR occurs and err_valid_o = 0, latch err_addr_o = wbm_adr_i, set err_cause_o and set err_valid_o.
  - If err_valid_o = 1, keep the first error and set err_ovf_o.
  - err_clr_i clears valid and ovf. A new error in the same cycle as err_clr_i is captured and valid stays 1, ovf stays 0.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. It clears on entry to BUSY.

Test Plan:
- Read 0x20000104 (GPIO, index 2), slave acks 3 cycles after its stb with dat 0xA5A5_0001 -> only wbs_cyc_o[2] rises, 1 cycle after the request. wbm_ack_o and wbm_dat_o = 0xA5A5_0001 appear in the same cycle as the slave ack. State returns to IDLE.
- Write 0x0000_0040 (DMEM) with sel=0x3, dat=0x1234 -> slave 4 sees adr, sel and dat unchanged with we=1. Completes on ack. No other cyc asserted.
- Access 0x5000_0000 (unmapped) -> no slave cyc. wbm_err_o pulses for 1 cycle, 1 cycle after the request. err_valid_o=1, err_addr_o=0x5000_0000, err_cause_o=01.
- TIMEOUT_CYCLES=4, slave 1 never acks -> slave strobe drops after 4 BUSY cycles, then a 1-cycle wbm_err_o. A second timeout sets err_ovf_o while err_addr_o keeps the first address. err_clr_i clears both.
- Edge cases:
  - Ack on the timeout cycle -> ack passed through, no err.
  - Master drops cyc mid-BUSY -> slave cyc drops in the same cycle, state IDLE.
  - wb_rst_i asserted mid-BUSY -> all strobes and status go to 0 asynchronously.
